// File: rtl/fifo_pkg.sv
// Shared defaults and the depth derivation for the threshold FIFO.
// Used by fifo_thresh_if, fifo_mem and fifo_thresh.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction
endpackage

// File: rtl/fifo_thresh_if.sv
// Request/status bundle between a FIFO user (master) and fifo_thresh (slave).
interface fifo_thresh_if #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  push, pop, data_in,
        output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one registered read port.
// The read register resets to 0; the array itself is never cleared.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read-before-write: a same-address read returns the old word (full push+pop).
    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with registered empty/full/almost flags and occupancy count.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags (tied to 0 otherwise).
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_thresh_if.slave  bus
);
    localparam int                  DEPTH   = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  push_acc, pop_acc;

    always_comb begin
        pop_acc  = bus.pop && !empty_q;
        push_acc = bus.push && (!full_q || pop_acc);
        wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags follow next-cycle count so they register in step with it.
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= (AF_LEVEL == 0);
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push_acc && rst_n),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .re_i    (pop_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q || (bus.push && !push_acc);
        unf_d = unf_q || (bus.pop && !pop_acc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh: queue-based model checked every cycle plus literal pins.
module tb_fifo_thresh;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fifo_thresh_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_thresh #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words, the last popped word, sticky errors.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf, m_unf;
    bit            started = 1'b0;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (!rst_n) begin
            mq.delete();
            m_dout  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            started = 1'b1;
        end else begin
            do_pop  = bus.pop && (mq.size() != 0);
            do_push = bus.push && ((mq.size() != DEPTH) || do_pop);
            if (do_pop)  m_dout = mq.pop_front();
            if (do_push) mq.push_back(bus.data_in);
            if (bus.push && !do_push) m_ovf = 1'b1;
            if (bus.pop && !do_pop)   m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_count", int'(bus.count), mq.size());
            chk("m_empty", int'(bus.empty), int'(mq.size() == 0));
            chk("m_full", int'(bus.full), int'(mq.size() == DEPTH));
            chk("m_af", int'(bus.almost_full), int'(mq.size() >= 14));
            chk("m_ae", int'(bus.almost_empty), int'(mq.size() <= 2));
            chk("m_dout", int'(bus.data_out), int'(m_dout));
            chk("m_ovf", int'(bus.overflow), ERR_EN ? int'(m_ovf) : 0);
            chk("m_unf", int'(bus.underflow), ERR_EN ? int'(m_unf) : 0);
        end
    end

    task automatic cyc(input bit pu, input bit po, input logic [DW-1:0] d);
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
    endtask

    initial begin
        // Requests held high through reset must be ignored.
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst_n    = 1'b1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_ae", int'(bus.almost_empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_af", int'(bus.almost_full), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_unf", int'(bus.underflow), 0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_count", int'(bus.count), i + 1);
            chk("fill_af", int'(bus.almost_full), int'(i + 1 >= 14));
            chk("fill_ae", int'(bus.almost_empty), int'(i + 1 <= 2));
        end
        chk("fill_full", int'(bus.full), 1);

        cyc(1'b1, 1'b0, 8'hAA);
        chk("ovf_count", int'(bus.count), 16);
        chk("ovf_flag", int'(bus.overflow), int'(ERR_EN));

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_dout", int'(bus.data_out), i);
        end
        chk("drain_empty", int'(bus.empty), 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_dout", int'(bus.data_out), 8'h0F);
        chk("unf_flag", int'(bus.underflow), int'(ERR_EN));

        cyc(1'b1, 1'b1, 8'h77);
        chk("pp_empty_count", int'(bus.count), 1);
        chk("pp_empty_dout", int'(bus.data_out), 8'h0F);
        cyc(1'b0, 1'b1, 8'h00);
        chk("pp_empty_pop", int'(bus.data_out), 8'h77);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h20 + k));
            chk("stream_count", int'(bus.count), 5);
            chk("stream_dout", int'(bus.data_out), (k < 5) ? 8'h10 + k : 8'h20 + k - 5);
        end

        // Queue now 0x43..0x47; top up to full, then push+pop at full.
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        chk("pp_full_pre", int'(bus.full), 1);
        cyc(1'b1, 1'b1, 8'hEE);
        chk("pp_full_count", int'(bus.count), 16);
        chk("pp_full_dout", int'(bus.data_out), 8'h43);

        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("pre_rst_count", int'(bus.count), 9);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 8'h99);
        rst_n = 1'b1;
        chk("mid_rst_count", int'(bus.count), 0);
        chk("mid_rst_empty", int'(bus.empty), 1);
        chk("mid_rst_dout", int'(bus.data_out), 0);
        chk("mid_rst_ovf", int'(bus.overflow), 0);
        chk("mid_rst_unf", int'(bus.underflow), 0);

        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", int'(bus.data_out), 8'h01);
        chk("post_rst_count", int'(bus.count), 1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of the storage depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the almost-full threshold in words.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the almost-empty threshold in words.
REQ-005 clk  in  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  in  1  is the reset; reset is synchronous and active-low.
REQ-007 push  in  1  is the write request, sampled each clock edge.
REQ-008 pop  in  1  is the read request, sampled each clock edge.
REQ-009 data_in  in  DATA_WIDTH  is the write data, valid when push=1.
REQ-010 data_out  out  DATA_WIDTH  is the registered read data.
REQ-011 empty  out  1  SHALL be 1 when count=0.
REQ-012 full  out  1  SHALL be 1 when count=DEPTH.
REQ-013 almost_full  out  1  SHALL be 1 when count>=AF_LEVEL.
REQ-014 almost_empty  out  1  SHALL be 1 when count<=AE_LEVEL.
REQ-015 count  out  ADDR_WIDTH+1  is the current occupancy, 0..DEPTH.
REQ-016 overflow  out  1  is the sticky overflow error flag (see Configuration).
REQ-017 underflow  out  1  is the sticky underflow error flag (see Configuration).

Function
REQ-018 A push SHALL be accepted when push=1 and (full=0 or an accepted pop occurs in the same cycle); the accepted word is written at wr_ptr, and wr_ptr then increments modulo DEPTH.
REQ-019 A pop SHALL be accepted when pop=1 and empty=0; the word at rd_ptr loads into data_out on that edge (1-cycle latency), and rd_ptr then increments modulo DEPTH.
REQ-020 data_out SHALL hold its value on every cycle without an accepted pop.
REQ-021 Push while full without pop, and pop while empty, SHALL be ignored: no pointer, count or data_out change.
REQ-022 Simultaneous push+pop while empty: only the push is accepted; count becomes 1.
REQ-023 Simultaneous push+pop while full: both accepted; count stays DEPTH; data_out gets the oldest word.
REQ-024 count SHALL be +1 on push-only, -1 on pop-only, and unchanged on both or neither.
REQ-025 All flags SHALL be registered and consistent with count in the same cycle; there is no combinational path from push/pop to any output.
REQ-026 Pointers SHALL be ADDR_WIDTH bits wide and wrap from DEPTH-1 to 0 with no gap.

Reset
REQ-027 When rst_n=0 at a clock edge: pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0 (1 if AF_LEVEL=0), overflow=0, underflow=0.
REQ-028 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-029 push/pop asserted during reset SHALL be ignored.

Configuration
REQ-030 Macro FIFO_ERR_FLAGS_EN defined: overflow SHALL set on any ignored push-while-full and underflow on any ignored pop-while-empty; both stay set until reset.
REQ-031 Macro FIFO_ERR_FLAGS_EN undefined: overflow and underflow ports SHALL exist and be tied to 0, with no error logic.

Structure
REQ-032 Package fifo_pkg SHALL hold the default width/depth constants and the DEPTH derivation function.
REQ-033 Storage SHALL be a sub-module fifo_mem: a 1-write/1-read synchronous dual-port array of DEPTH x DATA_WIDTH.
REQ-034 Pointer, count and flag logic SHALL stay in fifo_thresh.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=14, AE_LEVEL=2)
REQ-035 Reset, then 16 pushes of 0x00..0x0F -> count=16, full=1, almost_full asserted from count=14, almost_empty deasserted at count=3.
REQ-036 From full, a 17th push of 0xAA -> ignored; count=16; overflow=1 only with FIFO_ERR_FLAGS_EN.
REQ-037 16 pops -> data_out 0x00..0x0F, each one cycle after its pop; empty=1; an extra pop -> data_out holds 0x0F; underflow=1 only with the macro.
REQ-038 Push+pop simultaneously for 40 cycles at count=5 (pointers wrap) -> count stays 5 and output order matches input order.
REQ-039 Push+pop together when empty -> count=1, data_out unchanged; when full -> count=16, oldest word out.
REQ-040 Reset asserted with count=9 -> next cycle count=0, empty=1, data_out=0, error flags=0.
